// File: rtl/uart_hex_line_rx_if.sv
// Decoded byte stream from uart_hex_line_rx towards control.
// Master drives data/valid/last; slave drives ready.
interface uart_hex_line_rx_if;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_last;
  logic       i_ready;

  modport master (
    output o_data,
    output o_valid,
    output o_last,
    input  i_ready
  );

  modport slave (
    input  o_data,
    input  o_valid,
    input  o_last,
    output i_ready
  );
endinterface

// File: rtl/uart_hex_line_rx.sv
// ASCII hex-pair line decoder: buffers, validates and streams framed bytes.
// Define UART_HEX_CSUM_EN to treat each line's last byte as a zero-sum checksum.
module uart_hex_line_rx #(
  parameter int ADDR_W      = 6,
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [7:0]         i_uart_rdata,
  input  logic               i_uart_rready,
  output logic               o_uart_rreq,
  uart_hex_line_rx_if.master dout,
  output logic               o_err,
  output logic [2:0]         o_err_code,
  output logic               o_busy
);

  localparam int MAX_LEN = 1 << ADDR_W;
  localparam int LEN_W   = ADDR_W + 1;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  localparam bit TO_EN = TIMEOUT_CYC > 0;

  localparam logic [23:0] TO_LIM =
    TO_EN ? 24'(TIMEOUT_CYC - 1) : 24'd0;

  localparam logic [2:0] E_TO   = 3'd0;
  localparam logic [2:0] E_CHAR = 3'd1;
  localparam logic [2:0] E_ODD  = 3'd2;
  localparam logic [2:0] E_OVF  = 3'd3;
`ifdef UART_HEX_CSUM_EN
  localparam logic [2:0] E_CSUM = 3'd4;
`endif

  typedef enum logic [1:0] {
    S_RX,
    S_DRAIN,
    S_TX
  } state_t;

  state_t           state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] rd_q;
  logic             phase_q;
  logic [3:0]       nib_q;
  logic             pop_q;
  logic [23:0]      to_q;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             last_q;
`ifdef UART_HEX_CSUM_EN
  logic [7:0]       sum_q;
`endif

  logic [7:0] line_mem [MAX_LEN];

  logic       pop;
  logic       is_hex;
  logic       is_term;
  logic       is_sp;
  logic [3:0] hex_nib;
  logic [7:0] pair;
  logic       wr_en;
  logic [7:0] rd_byte;
  logic       to_run;
  logic       err_hit;
  logic [2:0] err_cd;
  logic       go_drain;
  logic       line_clr;
  logic       commit;

  // Pop alternates with a dead cycle so the show-ahead head can refresh.
  assign pop = !i_rst
             && state_q != S_TX
             && i_uart_rready
             && !pop_q;

  assign o_uart_rreq  = pop;
  assign dout.o_data  = data_q;
  assign dout.o_valid = valid_q;
  assign dout.o_last  = last_q;

  assign o_busy = state_q != S_RX
               || phase_q
               || len_q != '0;

  assign is_term = i_uart_rdata == 8'h0D
                || i_uart_rdata == 8'h0A;
  assign is_sp   = i_uart_rdata == 8'h20;
  assign pair    = {nib_q, hex_nib};
  assign rd_byte = line_mem[rd_q[ADDR_W-1:0]];

  assign wr_en = pop
              && state_q == S_RX
              && is_hex
              && phase_q
              && len_q != LEN_MAX;

  always_comb begin
    is_hex  = 1'b0;
    hex_nib = 4'h0;
    unique case (1'b1)
      (i_uart_rdata >= 8'h30 && i_uart_rdata <= 8'h39): begin
        is_hex  = 1'b1;
        hex_nib = 4'(i_uart_rdata - 8'h30);
      end
      (i_uart_rdata >= 8'h41 && i_uart_rdata <= 8'h46): begin
        is_hex  = 1'b1;
        hex_nib = 4'(i_uart_rdata - 8'h37);
      end
      (i_uart_rdata >= 8'h61 && i_uart_rdata <= 8'h66): begin
        is_hex  = 1'b1;
        hex_nib = 4'(i_uart_rdata - 8'h57);
      end
      default: ;
    endcase
  end

  always_comb begin
    err_hit  = 1'b0;
    err_cd   = E_TO;
    go_drain = 1'b0;
    line_clr = 1'b0;
    commit   = 1'b0;
    to_run   = TO_EN
            && state_q == S_RX
            && !pop
            && (phase_q || len_q != '0);
    if (state_q == S_RX && pop) begin
      unique case (1'b1)
        is_hex: begin
          if (phase_q && len_q == LEN_MAX) begin
            err_hit  = 1'b1;
            err_cd   = E_OVF;
            go_drain = 1'b1;
          end
        end
        is_sp: begin
          if (phase_q) begin
            err_hit  = 1'b1;
            err_cd   = E_CHAR;
            go_drain = 1'b1;
          end
        end
        is_term: begin
          if (phase_q) begin
            err_hit  = 1'b1;
            err_cd   = E_ODD;
            line_clr = 1'b1;
          end else if (len_q != '0) begin
`ifdef UART_HEX_CSUM_EN
            if (sum_q != 8'h00) begin
              err_hit  = 1'b1;
              err_cd   = E_CSUM;
              line_clr = 1'b1;
            end else if (len_q == LEN_ONE) begin
              line_clr = 1'b1;
            end else begin
              commit = 1'b1;
            end
`else
            commit = 1'b1;
`endif
          end
        end
        default: begin
          err_hit  = 1'b1;
          err_cd   = E_CHAR;
          go_drain = 1'b1;
        end
      endcase
    end else if (to_run && to_q == TO_LIM) begin
      err_hit  = 1'b1;
      err_cd   = E_TO;
      line_clr = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      line_mem[len_q[ADDR_W-1:0]] <= pair;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_RX;
      len_q      <= '0;
      rd_q       <= '0;
      phase_q    <= 1'b0;
      nib_q      <= '0;
      pop_q      <= 1'b0;
      to_q       <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      o_err      <= 1'b0;
      o_err_code <= '0;
`ifdef UART_HEX_CSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      pop_q <= pop;
      o_err <= err_hit;
      if (err_hit) begin
        o_err_code <= err_cd;
      end
      if (to_run && to_q != TO_LIM) begin
        to_q <= to_q + 24'd1;
      end else begin
        to_q <= '0;
      end
      case (state_q)
        S_RX: begin
          if (go_drain || line_clr) begin
            len_q   <= '0;
            phase_q <= 1'b0;
`ifdef UART_HEX_CSUM_EN
            sum_q   <= '0;
`endif
            if (go_drain) begin
              state_q <= S_DRAIN;
            end
          end else if (commit) begin
            state_q <= S_TX;
            rd_q    <= '0;
`ifdef UART_HEX_CSUM_EN
            // Checksum byte stays in the buffer but is not sent.
            len_q   <= len_q - LEN_ONE;
            sum_q   <= '0;
`endif
          end else if (pop && is_hex) begin
            nib_q   <= hex_nib;
            phase_q <= !phase_q;
            if (phase_q) begin
              len_q <= len_q + LEN_ONE;
`ifdef UART_HEX_CSUM_EN
              sum_q <= sum_q + pair;
`endif
            end
          end
        end
        S_DRAIN: begin
          if (pop && is_term) begin
            state_q <= S_RX;
          end
        end
        S_TX: begin
          if (!valid_q || dout.i_ready) begin
            if (valid_q && last_q) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              len_q   <= '0;
              state_q <= S_RX;
            end else begin
              valid_q <= 1'b1;
              data_q  <= rd_byte;
              last_q  <= rd_q == len_q - LEN_ONE;
              rd_q    <= rd_q + LEN_ONE;
            end
          end
        end
        default: state_q <= S_RX;
      endcase
    end
  end

endmodule
